// File: rtl/hwpe_ctrl_offload_arbiter.sv
// rtl/hwpe_ctrl_offload_arbiter.sv - round-robin arbiter with offload lock for the HWPE control slave port
module hwpe_ctrl_offload_arbiter #(
   parameter int          N_REQ        = 4,
   parameter int          AW           = 32,
   parameter int          DW           = 32,
   parameter logic [7:0]  TRIG_OFFS    = 8'h00,
   parameter logic [7:0]  TS_OFFS      = 8'h04,
   parameter int          LOCK_TIMEOUT = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*AW-1:0]     add_i,
   input  logic [N_REQ-1:0]        wen_i,
   input  logic [N_REQ*DW/8-1:0]   be_i,
   input  logic [N_REQ*DW-1:0]     data_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic [N_REQ*DW-1:0]     r_data_o,
   output logic [N_REQ-1:0]        r_valid_o,
   output logic                    cfg_req_o,
   output logic [AW-1:0]           cfg_add_o,
   output logic                    cfg_wen_o,
   output logic [DW/8-1:0]         cfg_be_o,
   output logic [DW-1:0]           cfg_data_o,
   output logic [N_REQ-1:0]        cfg_id_o,
   input  logic                    cfg_gnt_i,
   input  logic [DW-1:0]           cfg_r_data_i,
   input  logic                    cfg_r_valid_i,
   output logic                    lock_valid_o,
   output logic [N_REQ-1:0]        lock_owner_o,
   output logic                    timeout_evt_o
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

   typedef enum logic {FREE, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  owner_q, owner_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              acq_pend_q, acq_pend_d;
   logic              evt_q, evt_d;
   logic [IW-1:0]     rr_q;
   logic [IW-1:0]     resp_idx_q;
   logic              resp_pend_q;

   logic [N_REQ-1:0]  eligible;
   logic              found;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     cand;
   logic [N_REQ-1:0]  win_oh;
   logic              granted;
   logic              is_ts_rd;
   logic              is_trig_wr;
   logic              busy_reply;
   logic              tmo_hit;

   // Pick the first eligible requester at or after the round-robin pointer
   always_comb begin
      eligible = (state_q == LOCKED) ? (req_i & owner_q) : req_i;
      found    = 1'b0;
      win_idx  = '0;
      cand     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IW'((int'(rr_q) + i) % N_REQ);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign win_oh     = found ? (N_REQ'(1) << win_idx) : '0;
   assign cfg_req_o  = found;
   assign cfg_id_o   = win_oh;
   assign cfg_add_o  = found ? add_i[win_idx*AW +: AW] : '0;
   assign cfg_wen_o  = found ? wen_i[win_idx] : 1'b0;
   assign cfg_be_o   = found ? be_i[win_idx*(DW/8) +: DW/8] : '0;
   assign cfg_data_o = found ? data_i[win_idx*DW +: DW] : '0;
   assign granted    = found & cfg_gnt_i;
   assign gnt_o      = granted ? win_oh : '0;

   // Every port sees the slave read data; only r_valid_o steers it
   assign r_data_o   = {N_REQ{cfg_r_data_i}};
   assign r_valid_o  = (cfg_r_valid_i & resp_pend_q) ? (N_REQ'(1) << resp_idx_q) : '0;

   assign is_ts_rd   = granted & cfg_wen_o & (cfg_add_o[7:0] == TS_OFFS);
   assign is_trig_wr = granted & ~cfg_wen_o & (cfg_add_o[7:0] == TRIG_OFFS);
   assign busy_reply = acq_pend_q & cfg_r_valid_i & cfg_r_data_i[DW-1];
   assign tmo_hit    = (timer_q == TW'(LOCK_TIMEOUT - 1));

   assign lock_valid_o  = (state_q == LOCKED);
   assign lock_owner_o  = owner_q;
   assign timeout_evt_o = evt_q;

   // Lock FSM next state: clear > owner trigger > busy reply > timeout
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      timer_d    = timer_q;
      acq_pend_d = 1'b0;
      evt_d      = 1'b0;
      if (clear_i) begin
         state_d = FREE;
         owner_d = '0;
         timer_d = '0;
      end else begin
         case (state_q)
            FREE: begin
               if (is_ts_rd) begin
                  state_d    = LOCKED;
                  owner_d    = win_oh;
                  timer_d    = '0;
                  acq_pend_d = 1'b1;
               end
            end
            LOCKED: begin
               if (is_trig_wr || busy_reply) begin
                  state_d = FREE;
                  owner_d = '0;
                  timer_d = '0;
               end else if (granted) begin
                  // only the owner is eligible here, so any grant is an owner grant
                  timer_d = '0;
               end else if (tmo_hit) begin
                  state_d = FREE;
                  owner_d = '0;
                  timer_d = '0;
                  evt_d   = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               state_d = FREE;
               owner_d = '0;
               timer_d = '0;
            end
         endcase
      end
   end

   // Lock FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= FREE;
         owner_q    <= '0;
         timer_q    <= '0;
         acq_pend_q <= 1'b0;
         evt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         timer_q    <= timer_d;
         acq_pend_q <= acq_pend_d;
         evt_q      <= evt_d;
      end
   end

   // Round-robin pointer and response routing follow each grant; clear leaves them alone
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q        <= '0;
         resp_idx_q  <= '0;
         resp_pend_q <= 1'b0;
      end else begin
         resp_pend_q <= granted;
         if (granted) begin
            rr_q       <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
            resp_idx_q <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_offload_arbiter.sv
// tb/tb_hwpe_ctrl_offload_arbiter.sv - self-checking bench for hwpe_ctrl_offload_arbiter
module tb_hwpe_ctrl_offload_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LT = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear_i;
   logic [N-1:0]      req_i;
   logic [N*AW-1:0]   add_i;
   logic [N-1:0]      wen_i;
   logic [N*DW/8-1:0] be_i;
   logic [N*DW-1:0]   data_i;
   logic [N-1:0]      gnt_o;
   logic [N*DW-1:0]   r_data_o;
   logic [N-1:0]      r_valid_o;
   logic              cfg_req_o;
   logic [AW-1:0]     cfg_add_o;
   logic              cfg_wen_o;
   logic [DW/8-1:0]   cfg_be_o;
   logic [DW-1:0]     cfg_data_o;
   logic [N-1:0]      cfg_id_o;
   logic              cfg_gnt_i;
   logic [DW-1:0]     cfg_r_data_i;
   logic              cfg_r_valid_i;
   logic              lock_valid_o;
   logic [N-1:0]      lock_owner_o;
   logic              timeout_evt_o;

   hwpe_ctrl_offload_arbiter #(
      .N_REQ(N), .AW(AW), .DW(DW), .TRIG_OFFS(8'h00), .TS_OFFS(8'h04), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear_i),
      .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i),
      .gnt_o(gnt_o), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
      .cfg_req_o(cfg_req_o), .cfg_add_o(cfg_add_o), .cfg_wen_o(cfg_wen_o),
      .cfg_be_o(cfg_be_o), .cfg_data_o(cfg_data_o), .cfg_id_o(cfg_id_o),
      .cfg_gnt_i(cfg_gnt_i), .cfg_r_data_i(cfg_r_data_i), .cfg_r_valid_i(cfg_r_valid_i),
      .lock_valid_o(lock_valid_o), .lock_owner_o(lock_owner_o), .timeout_evt_o(timeout_evt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Per-core transaction fields driven by the stimulus
   logic [AW-1:0] c_add [N];
   logic          c_wen [N];

   // Reference model state
   bit m_lock, m_pend, m_acq, m_evt;
   int m_owner, m_rr, m_quiet, m_pidx;

   // Model and compare on every falling edge
   always @(negedge clk) begin : model_cmp
      int w;
      bit found, grn, ts, trig, busy;
      logic [N-1:0] exp_rv;
      if (rst) begin
         m_lock = 0; m_pend = 0; m_acq = 0; m_evt = 0;
         m_owner = 0; m_rr = 0; m_quiet = 0; m_pidx = 0;
      end else begin
         found = 0;
         w = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (!found && req_i[c] && (!m_lock || m_owner == c)) begin
               found = 1;
               w = c;
            end
         end
         grn = found && cfg_gnt_i;
         chk("cfg_req", cfg_req_o, found);
         chk("gnt", gnt_o, grn ? (4'b0001 << w) : 4'b0000);
         if (found) begin
            chk("cfg_id", cfg_id_o, 4'b0001 << w);
            chk("cfg_add", cfg_add_o, add_i[w*AW +: AW]);
            chk("cfg_wen", cfg_wen_o, wen_i[w]);
            chk("cfg_be", cfg_be_o, be_i[w*4 +: 4]);
            chk("cfg_data", cfg_data_o, data_i[w*DW +: DW]);
         end
         exp_rv = (cfg_r_valid_i && m_pend) ? (4'b0001 << m_pidx) : 4'b0000;
         chk("r_valid", r_valid_o, exp_rv);
         chk("r_data", r_data_o, {N{cfg_r_data_i}});
         chk("lock_valid", lock_valid_o, m_lock);
         chk("lock_owner", lock_owner_o, m_lock ? (4'b0001 << m_owner) : 4'b0000);
         chk("timeout_evt", timeout_evt_o, m_evt);

         ts   = grn && wen_i[w] && (add_i[w*AW +: 8] == 8'h04);
         trig = grn && !wen_i[w] && (add_i[w*AW +: 8] == 8'h00);
         busy = m_acq && cfg_r_valid_i && cfg_r_data_i[DW-1];
         m_evt = 0;
         m_acq = 0;
         if (clear_i) begin
            m_lock = 0; m_quiet = 0;
         end else if (!m_lock) begin
            if (ts) begin
               m_lock = 1; m_owner = w; m_quiet = 0; m_acq = 1;
            end
         end else if (trig || busy) begin
            m_lock = 0; m_quiet = 0;
         end else if (grn) begin
            m_quiet = 0;
         end else begin
            m_quiet++;
            if (m_quiet == LT) begin
               m_lock = 0; m_quiet = 0; m_evt = 1;
            end
         end
         if (grn) begin
            m_rr = (w + 1) % N;
            m_pidx = w;
         end
         m_pend = grn;
      end
   end

   task automatic setc(input int c, input bit wen, input logic [7:0] off);
      c_wen[c] = wen;
      c_add[c] = 32'h1A10_0000 | {24'h0, off};
   endtask

   // One clock of stimulus; the slave answers one cycle after each modelled grant
   task automatic cyc(input logic [N-1:0] req, input logic gnt, input logic clr, input logic [DW-1:0] reply);
      @(posedge clk);
      #1;
      req_i         = req;
      cfg_gnt_i     = gnt;
      clear_i       = clr;
      cfg_r_valid_i = m_pend;
      cfg_r_data_i  = reply;
      for (int c = 0; c < N; c++) begin
         add_i[c*AW +: AW]  = c_add[c];
         wen_i[c]           = c_wen[c];
         be_i[c*4 +: 4]     = 4'(c + 1);
         data_i[c*DW +: DW] = 32'hC0DE_0000 + c_add[c][7:0] + 32'(c * 256);
      end
      @(negedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1; clear_i = 0; req_i = '0; add_i = '0; wen_i = '0; be_i = '0; data_i = '0;
      cfg_gnt_i = 0; cfg_r_data_i = '0; cfg_r_valid_i = 0;
      for (int c = 0; c < N; c++) setc(c, 1'b1, 8'h10);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_req", cfg_req_o, 1'b0);
      chk("rst_gnt", gnt_o, 4'b0000);
      chk("rst_lock_valid", lock_valid_o, 1'b0);
      chk("rst_lock_owner", lock_owner_o, 4'b0000);
      chk("rst_timeout", timeout_evt_o, 1'b0);
      @(posedge clk);
      #1;
      rst = 0;
      cyc(4'b0000, 1'b0, 1'b0, '0);
      chk("idle_cfg_req", cfg_req_o, 1'b0);
      chk("idle_lock_owner", lock_owner_o, 4'b0000);

      // All four cores read 0x10: plain round robin
      cyc(4'b1111, 1'b1, 1'b0, '0);
      chk("rr_gnt_c0", gnt_o, 4'b0001);
      cyc(4'b1111, 1'b1, 1'b0, '0);
      chk("rr_gnt_c1", gnt_o, 4'b0010);
      chk("rr_rv_c0", r_valid_o, 4'b0001);
      cyc(4'b1111, 1'b1, 1'b0, '0);
      chk("rr_gnt_c2", gnt_o, 4'b0100);
      chk("rr_rv_c1", r_valid_o, 4'b0010);
      cyc(4'b1111, 1'b1, 1'b0, '0);
      chk("rr_gnt_c3", gnt_o, 4'b1000);
      chk("rr_rv_c2", r_valid_o, 4'b0100);
      cyc(4'b0000, 1'b0, 1'b0, 32'h1234_5678);
      chk("rr_rv_c3", r_valid_o, 4'b1000);
      chk("rr_rdata_c3", r_data_o[3*DW +: DW], 32'h1234_5678);

      // Core 2 acquires; core 0 is blocked until core 2 triggers
      setc(2, 1'b1, 8'h04);
      cyc(4'b0100, 1'b1, 1'b0, '0);
      chk("lk_gnt_c2", gnt_o, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0001, 1'b1, 1'b0, '0);
         chk("lk_owner_c2", lock_owner_o, 4'b0100);
         chk("lk_block_c0", gnt_o[0], 1'b0);
      end
      setc(2, 1'b0, 8'h00);
      cyc(4'b0101, 1'b1, 1'b0, '0);
      chk("lk_trig_c2", gnt_o, 4'b0100);
      cyc(4'b0001, 1'b1, 1'b0, '0);
      chk("lk_after_c0", gnt_o, 4'b0001);
      chk("lk_after_free", lock_valid_o, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0, '0);

      // Core 1 acquire answered busy; others served afterwards
      setc(1, 1'b1, 8'h04);
      setc(0, 1'b1, 8'h10); setc(2, 1'b1, 8'h10); setc(3, 1'b1, 8'h10);
      cyc(4'b0010, 1'b1, 1'b0, '0);
      chk("busy_gnt_c1", gnt_o, 4'b0010);
      cyc(4'b1101, 1'b1, 1'b0, 32'hFFFF_FFFF);
      chk("busy_resp_locked", lock_valid_o, 1'b1);
      chk("busy_resp_gnt", gnt_o, 4'b0000);
      cyc(4'b1101, 1'b1, 1'b0, '0);
      chk("busy_freed", lock_valid_o, 1'b0);
      chk("busy_gnt_c2", gnt_o, 4'b0100);
      cyc(4'b1101, 1'b1, 1'b0, '0);
      chk("busy_gnt_c3", gnt_o, 4'b1000);
      cyc(4'b1101, 1'b1, 1'b0, '0);
      chk("busy_gnt_c0", gnt_o, 4'b0001);
      cyc(4'b0000, 1'b0, 1'b0, '0);

      // Core 3 locks then goes silent: forced release
      setc(3, 1'b1, 8'h04);
      cyc(4'b1000, 1'b1, 1'b0, '0);
      chk("tmo_gnt_c3", gnt_o, 4'b1000);
      for (int i = 1; i <= 9; i++) begin
         cyc(4'b0000, 1'b0, 1'b0, '0);
         if (i < 9) begin
            chk("tmo_held", lock_valid_o, 1'b1);
            chk("tmo_no_evt", timeout_evt_o, 1'b0);
         end else begin
            chk("tmo_evt", timeout_evt_o, 1'b1);
            chk("tmo_freed", lock_valid_o, 1'b0);
         end
      end
      cyc(4'b0000, 1'b0, 1'b0, '0);
      chk("tmo_pulse_end", timeout_evt_o, 1'b0);

      // Owner trigger lands on the timeout cycle: no event
      setc(0, 1'b1, 8'h04);
      cyc(4'b0001, 1'b1, 1'b0, '0);
      repeat (7) cyc(4'b0000, 1'b0, 1'b0, '0);
      setc(0, 1'b0, 8'h00);
      cyc(4'b0001, 1'b1, 1'b0, '0);
      chk("trigtmo_gnt", gnt_o, 4'b0001);
      cyc(4'b0000, 1'b0, 1'b0, '0);
      chk("trigtmo_no_evt", timeout_evt_o, 1'b0);
      chk("trigtmo_free", lock_valid_o, 1'b0);

      // Clear while locked; the in-flight response still reaches core 1
      setc(1, 1'b1, 8'h04);
      cyc(4'b0010, 1'b1, 1'b0, '0);
      cyc(4'b0000, 1'b0, 1'b0, '0);
      setc(1, 1'b1, 8'h10);
      cyc(4'b0010, 1'b1, 1'b1, '0);
      chk("clr_gnt_c1", gnt_o, 4'b0010);
      cyc(4'b0000, 1'b0, 1'b0, 32'hCAFE_F00D);
      chk("clr_free", lock_valid_o, 1'b0);
      chk("clr_rv_c1", r_valid_o, 4'b0010);
      chk("clr_rdata_c1", r_data_o[1*DW +: DW], 32'hCAFE_F00D);

      // Owner re-issues test&set: timer refresh, busy-looking reply ignored
      setc(2, 1'b1, 8'h04);
      cyc(4'b0100, 1'b1, 1'b0, '0);
      repeat (5) cyc(4'b0000, 1'b0, 1'b0, '0);
      cyc(4'b0100, 1'b1, 1'b0, '0);
      chk("refresh_gnt", gnt_o, 4'b0100);
      for (int i = 1; i <= 8; i++) begin
         cyc(4'b0000, 1'b0, 1'b0, (i == 1) ? 32'hFFFF_FFFF : 32'h0);
         chk("refresh_held", lock_valid_o, 1'b1);
         chk("refresh_no_evt", timeout_evt_o, 1'b0);
      end
      cyc(4'b0000, 1'b0, 1'b0, '0);
      chk("refresh_evt", timeout_evt_o, 1'b1);
      cyc(4'b0000, 1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
